// File: rtl/mul30_rr_sched.sv
// mul30_rr_sched: round-robin arbiter feeding one shared pipelined 30x30 multiplier.
// Each issued product carries a tag through a shadow pipeline.
// The tag routes the result back to its requester and keeps per-requester in-flight counts.
module mul30_rr_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pause,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [30*NREQ-1:0] req_a,
    input  logic [30*NREQ-1:0] req_b,
    output logic [NREQ-1:0]    req_ready,
    output logic [29:0]        mul_a,
    output logic [29:0]        mul_b,
    input  logic [59:0]        mul_c,
    output logic [NREQ-1:0]    res_valid,
    output logic [59:0]        res_data,
    output logic               idle
);

    localparam int unsigned OPW  = 30;
    localparam int unsigned PRW  = 60;
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNTW = 4;
    localparam int unsigned TDEP = MUL_LAT + 1;

    logic [IDW-1:0]  rr_q, rr_d;
    logic [OPW-1:0]  mul_a_q, mul_a_d;
    logic [OPW-1:0]  mul_b_q, mul_b_d;
    logic [TDEP-1:0] tag_vld_q, tag_vld_d;
    logic [IDW-1:0]  tag_id_q [TDEP];
    logic [IDW-1:0]  tag_id_d [TDEP];
    logic [NREQ-1:0] res_valid_q, res_valid_d;
    logic [PRW-1:0]  res_data_q, res_data_d;
    logic [CNTW-1:0] out_cnt_q [NREQ];
    logic [CNTW-1:0] out_cnt_d [NREQ];

    logic            gnt_vld;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  scan_id;
    logic            last_vld;
    logic [IDW-1:0]  last_id;

    assign last_vld = tag_vld_q[TDEP-1];
    assign last_id  = tag_id_q[TDEP-1];

    // Round-robin search from rr; eligibility uses the registered in-flight count
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        scan_id = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_id = IDW'((32'(rr_q) + k) % NREQ);
            if (!gnt_vld && !pause && req_valid[scan_id] &&
                (out_cnt_q[scan_id] < CNTW'(MAX_OUT))) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_id;
            end
        end
    end

    assign req_ready = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;

    // Next state: operand capture, tag shift, result capture, in-flight counters
    always_comb begin
        rr_d        = rr_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        tag_vld_d   = '0;
        res_valid_d = '0;
        res_data_d  = res_data_q;
        for (int unsigned s = 0; s < TDEP; s++) begin
            tag_id_d[s] = '0;
        end

        if (gnt_vld) begin
            rr_d    = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
            mul_a_d = req_a[OPW*gnt_idx +: OPW];
            mul_b_d = req_b[OPW*gnt_idx +: OPW];
        end

        tag_vld_d[0] = gnt_vld;
        tag_id_d[0]  = gnt_idx;
        for (int unsigned s = 1; s < TDEP; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end

        if (last_vld) begin
            res_data_d  = mul_c;
            res_valid_d = NREQ'(1) << last_id;
        end

        for (int unsigned i = 0; i < NREQ; i++) begin
            out_cnt_d[i] = out_cnt_q[i];
            if ((gnt_vld && (gnt_idx == IDW'(i))) && !(last_vld && (last_id == IDW'(i)))) begin
                out_cnt_d[i] = out_cnt_q[i] + CNTW'(1);
            end else if (!(gnt_vld && (gnt_idx == IDW'(i))) && (last_vld && (last_id == IDW'(i)))) begin
                out_cnt_d[i] = out_cnt_q[i] - CNTW'(1);
            end
        end
    end

    // State registers; reset discards every in-flight tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            tag_vld_q   <= '0;
            res_valid_q <= '0;
            res_data_q  <= '0;
            for (int unsigned s = 0; s < TDEP; s++) begin
                tag_id_q[s] <= '0;
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                out_cnt_q[i] <= '0;
            end
        end else begin
            rr_q        <= rr_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            tag_vld_q   <= tag_vld_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            for (int unsigned s = 0; s < TDEP; s++) begin
                tag_id_q[s] <= tag_id_d[s];
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                out_cnt_q[i] <= out_cnt_d[i];
            end
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

    // Idle once no tag is in flight, no result is being presented and nothing is granted
    assign idle = ~|tag_vld_q & ~|res_valid_q & ~|req_ready;

endmodule

// File: tb/tb_mul30_rr_sched.sv
// Testbench for mul30_rr_sched: queue-based reference model plus directed literal checks.
module tb_mul30_rr_sched;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned LAT     = MUL_LAT + 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 pause;
    logic [NREQ-1:0]      req_valid;
    logic [30*NREQ-1:0]   req_a;
    logic [30*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic [29:0]          mul_a;
    logic [29:0]          mul_b;
    logic [59:0]          mul_c;
    logic [NREQ-1:0]      res_valid;
    logic [59:0]          res_data;
    logic                 idle;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul30_rr_sched #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pause     (pause),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_c     (mul_c),
        .res_valid (res_valid),
        .res_data  (res_data),
        .idle      (idle)
    );

    // Attached multiplier: MUL_LAT register stages, no reset
    logic [59:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        mpipe[0] <= 60'(mul_a) * 60'(mul_b);
        for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_c = mpipe[MUL_LAT-1];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [29:0] a, input logic [29:0] b);
        req_a[30*i +: 30] = a;
        req_b[30*i +: 30] = b;
    endtask

    // Reference model: products in flight with their due cycle
    typedef struct {
        int unsigned due;
        int unsigned id;
        logic [59:0] prod;
    } fl_t;

    fl_t         fq[$];
    int unsigned m_cnt [NREQ];
    int unsigned m_rr;
    logic [29:0] m_mul_a, m_mul_b;
    logic [59:0] m_last;
    int unsigned cyc = 0;
    int unsigned waitc [NREQ];
    int unsigned max_wait = 0;

    // Compare process: model prediction vs DUT on every falling edge
    always @(negedge clk) begin
        logic [NREQ-1:0] e_rdy, e_rv;
        logic [59:0]     e_rd;
        logic            e_idle;
        logic            elig;
        int              g;
        int unsigned     ix;
        logic [29:0]     ga, gb;

        if (!rst_n) begin
            fq.delete();
            for (int i = 0; i < NREQ; i++) begin
                m_cnt[i] = 0;
                waitc[i] = 0;
            end
            m_rr    = 0;
            m_mul_a = '0;
            m_mul_b = '0;
            m_last  = '0;
            check("rst_req_ready", 64'(req_ready), 64'(0));
            check("rst_res_valid", 64'(res_valid), 64'(0));
            check("rst_res_data",  64'(res_data),  64'(0));
            check("rst_mul_a",     64'(mul_a),     64'(0));
            check("rst_mul_b",     64'(mul_b),     64'(0));
            check("rst_idle",      64'(idle),      64'(1));
        end else begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                ix = (m_rr + k) % NREQ;
                if (g < 0 && !pause && req_valid[ix] && m_cnt[ix] < MAX_OUT) g = int'(ix);
            end
            e_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
            e_rv  = '0;
            e_rd  = m_last;
            if (fq.size() > 0 && fq[0].due == cyc) begin
                e_rv = NREQ'(1) << fq[0].id;
                e_rd = fq[0].prod;
            end
            e_idle = (fq.size() == 0) && (g < 0);

            check("req_ready", 64'(req_ready), 64'(e_rdy));
            check("res_valid", 64'(res_valid), 64'(e_rv));
            check("res_data",  64'(res_data),  64'(e_rd));
            check("mul_a",     64'(mul_a),     64'(m_mul_a));
            check("mul_b",     64'(mul_b),     64'(m_mul_b));
            check("idle",      64'(idle),      64'(e_idle));
            check("res_onehot", 64'($countones(res_valid) <= 1), 64'(1));

            for (int i = 0; i < NREQ; i++) begin
                elig = req_valid[i] && !pause && (m_cnt[i] < MAX_OUT);
                if (elig && !req_ready[i]) begin
                    waitc[i]++;
                    if (waitc[i] > max_wait) max_wait = waitc[i];
                end else begin
                    waitc[i] = 0;
                end
            end

            if (g >= 0) begin
                ga = req_a[30*g +: 30];
                gb = req_b[30*g +: 30];
                fq.push_back('{due: cyc + LAT, id: g, prod: 60'(ga) * 60'(gb)});
                m_cnt[g]++;
                m_rr    = (g + 1) % NREQ;
                m_mul_a = ga;
                m_mul_b = gb;
            end
            foreach (fq[j]) if (fq[j].due == cyc + 1) m_cnt[fq[j].id]--;
            if (fq.size() > 0 && fq[0].due == cyc) begin
                m_last = fq[0].prod;
                void'(fq.pop_front());
            end
        end
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Directed and random stimulus
    initial begin
        int nres;
        logic [NREQ-1:0] exp_oh;
        rst_n = 1'b0; pause = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Full contention: a=i+1, b=1000, grants rotate from 0
        for (int i = 0; i < NREQ; i++) set_op(i, 30'(i + 1), 30'd1000);
        req_valid = '1;
        for (int k = 0; k < 12; k++) begin
            #1;
            exp_oh = NREQ'(1) << (k % 4);
            check("cont_grant", 64'(req_ready), 64'(exp_oh));
            if (k >= 5) begin
                exp_oh = NREQ'(1) << ((k - 5) % 4);
                check("cont_rv", 64'(res_valid), 64'(exp_oh));
                check("cont_rd", 64'(res_data), 64'(((k - 5) % 4 + 1) * 1000));
            end
            tick();
        end
        req_valid = '0;
        repeat (7) tick();

        // Single op on requester 2 with maximum operands
        set_op(2, 30'h3FFFFFFF, 30'h3FFFFFFF);
        req_valid = 4'b0100;
        #1 check("single_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        repeat (4) tick();
        check("single_rv", 64'(res_valid), 64'h4);
        check("single_rd", 64'(res_data), 64'h0FFFFFFF80000001);
        check("single_busy", 64'(idle), 64'(0));
        tick();
        check("single_idle", 64'(idle), 64'(1));
        repeat (2) tick();

        // Outstanding cap: requester 1 alone, granted unless 4 are in flight
        set_op(1, 30'd7, 30'd9);
        req_valid = 4'b0010;
        for (int k = 0; k < 15; k++) begin
            #1 check("cap_grant", 64'(req_ready), 64'((k % 5 == 4) ? 4'b0000 : 4'b0010));
            tick();
        end
        req_valid = '0;
        repeat (7) tick();

        // Pause with three products in flight
        for (int i = 0; i < NREQ; i++) set_op(i, 30'(100 + i), 30'(3 + i));
        req_valid = 4'b1011;
        repeat (3) tick();
        req_valid = '1;
        pause = 1'b1;
        nres = 0;
        for (int k = 0; k < 8; k++) begin
            #1 check("pause_ready", 64'(req_ready), 64'(0));
            if (res_valid != '0) nres++;
            if (k == 4) check("pause_busy", 64'(idle), 64'(0));
            if (k == 5) check("pause_idle", 64'(idle), 64'(1));
            tick();
        end
        check("pause_nres", 64'(nres), 64'(3));
        pause = 1'b0;
        req_valid = '0;
        repeat (2) tick();

        // Reset two cycles after three issues; products must vanish
        req_valid = 4'b0001; tick();
        req_valid = 4'b0010; tick();
        req_valid = 4'b0100; tick();
        req_valid = '0;      tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        nres = 0;
        for (int k = 0; k < 8; k++) begin
            #1 if (res_valid != '0) nres++;
            tick();
        end
        check("rst_lost_results", 64'(nres), 64'(0));
        req_valid = '1;
        #1 check("rst_rr_zero", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        repeat (7) tick();

        // Random traffic
        for (int n = 0; n < 10000; n++) begin
            req_valid = NREQ'($urandom);
            pause = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 7) == 0) set_op(i, 30'h3FFFFFFF, 30'($urandom));
                else set_op(i, 30'($urandom), 30'($urandom));
            end
            tick();
        end
        req_valid = '0;
        pause = 1'b0;
        repeat (8) tick();
        check("starve_bound", 64'(max_wait <= NREQ - 1), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
